// File: rtl/gpgpu_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package gpgpu_arb_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  // Index width that stays at least one bit wide for tiny requester counts.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gpgpu_rr_pick_first.sv
// Combinational rotating lowest-first picker: first set request at or above ptr, wrapping.
module gpgpu_rr_pick_first
  import gpgpu_arb_pkg::*;
#(
  parameter int NUM_REQ   = 8,
  parameter int IDX_WIDTH = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [IDX_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]   pick_oh_o,
  output logic [IDX_WIDTH-1:0] pick_idx_o,
  output logic                 any_o
);

  logic [2*NUM_REQ-1:0] req_dbl;
  int                   lo;

  assign req_dbl = {req_i, req_i};

  // The doubled vector turns the wrap-around search into a plain window [ptr, ptr+NUM_REQ).
  always_comb begin
    any_o      = 1'b0;
    pick_idx_o = '0;
    pick_oh_o  = '0;
    lo         = int'(ptr_i);
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      if (!any_o && (i >= lo) && (i < lo + NUM_REQ) && req_dbl[i]) begin
        any_o      = 1'b1;
        pick_idx_o = IDX_WIDTH'((i >= NUM_REQ) ? (i - NUM_REQ) : i);
      end
    end
    pick_oh_o[pick_idx_o] = any_o;
  end

endmodule

// File: rtl/gpgpu_rr_arb_bin.sv
// Round-robin arbiter with registered one-hot + binary grant behind a valid/ready stage.
// Optional multi-beat locking enabled by defining GPGPU_RR_ARB_BIN_LOCK_EN.
module gpgpu_rr_arb_bin
  import gpgpu_arb_pkg::*;
#(
  parameter int NUM_REQ   = 8,
  parameter int IDX_WIDTH = clog2_min1(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [NUM_REQ-1:0]   grant_oh_o,
  output logic [IDX_WIDTH-1:0] grant_idx_o
`ifdef GPGPU_RR_ARB_BIN_LOCK_EN
  ,
  input  logic                 lock_i
`endif
);

  arb_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_oh_q, grant_oh_d;
  logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDX_WIDTH-1:0] pick_idx;
  logic                 pick_any;
  logic                 hs, load, lock_hit;

  gpgpu_rr_pick_first #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req_i      (req_i),
    .ptr_i      (ptr_q),
    .pick_oh_o  (pick_oh),
    .pick_idx_o (pick_idx),
    .any_o      (pick_any)
  );

  assign hs   = (state_q == FULL) & out_ready_i;
  assign load = ((state_q == EMPTY) | hs) & pick_any;

`ifdef GPGPU_RR_ARB_BIN_LOCK_EN
  assign lock_hit = hs & lock_i & req_i[grant_idx_q];
`else
  assign lock_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_oh_d  = grant_oh_q;
    grant_idx_d = grant_idx_q;
    if (lock_hit) begin
      // Re-issue the same grant; ptr stays put so fairness resumes after the burst.
      state_d = FULL;
    end else if (load) begin
      state_d     = FULL;
      grant_oh_d  = pick_oh;
      grant_idx_d = pick_idx;
      ptr_d       = (pick_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end else if (hs) begin
      state_d     = EMPTY;
      grant_oh_d  = '0;
      grant_idx_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      ptr_q       <= '0;
      grant_oh_q  <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_oh_q  <= grant_oh_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign out_valid_o = (state_q == FULL);
  assign grant_oh_o  = grant_oh_q;
  assign grant_idx_o = grant_idx_q;

endmodule

// File: tb/tb_gpgpu_rr_arb_bin.sv
// Directed self-checking bench: one 8-requester and one 5-requester arbiter.
module tb_gpgpu_rr_arb_bin;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req8;
  logic       rdy8;
  logic       vld8;
  logic [7:0] oh8;
  logic [2:0] idx8;
  logic [4:0] req5;
  logic       rdy5;
  logic       vld5;
  logic [4:0] oh5;
  logic [2:0] idx5;
  logic       lock8;
  logic       lock5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpgpu_rr_arb_bin #(.NUM_REQ(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req8),
    .out_valid_o (vld8),
    .out_ready_i (rdy8),
    .grant_oh_o  (oh8),
    .grant_idx_o (idx8)
`ifdef GPGPU_RR_ARB_BIN_LOCK_EN
    ,
    .lock_i      (lock8)
`endif
  );

  gpgpu_rr_arb_bin #(.NUM_REQ(5)) dut5 (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req5),
    .out_valid_o (vld5),
    .out_ready_i (rdy5),
    .grant_oh_o  (oh5),
    .grant_idx_o (idx5)
`ifdef GPGPU_RR_ARB_BIN_LOCK_EN
    ,
    .lock_i      (lock5)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks valid, one-hot and index of the 8-requester instance together.
  task automatic chk8(input string tag, input logic v, input int idx);
    logic [7:0] e_oh;
    e_oh = v ? (8'h01 << idx) : 8'h00;
    chk({tag, "_vld"}, {31'd0, vld8}, {31'd0, v});
    chk({tag, "_oh"},  {24'd0, oh8},  {24'd0, e_oh});
    chk({tag, "_idx"}, {29'd0, idx8}, v ? idx : 0);
  endtask

  task automatic chk5(input string tag, input int idx);
    logic [4:0] e_oh;
    e_oh = 5'h01 << idx;
    chk({tag, "_vld"}, {31'd0, vld5}, 32'd1);
    chk({tag, "_oh"},  {27'd0, oh5},  {27'd0, e_oh});
    chk({tag, "_idx"}, {29'd0, idx5}, idx);
    chk({tag, "_ptr"}, {31'd0, (dut5.ptr_q < 3'd5)}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req8 = '0; rdy8 = 1'b0; req5 = '0; rdy5 = 1'b0;
    lock8 = 1'b0; lock5 = 1'b0;
    step();
    chk8("reset", 1'b0, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      chk8("idle", 1'b0, 0);
    end

    // Full rotation 0..7 then wrap to 0.
    req8 = 8'hFF; rdy8 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk8("rot", 1'b1, k % 8);
    end

    // Backpressure: ptr is 1, req 0x24 -> grant 2, held while ready low.
    req8 = 8'h24;
    step();
    chk8("bp_load", 1'b1, 2);
    rdy8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req8 = (i == 2) ? 8'h20 : 8'h24;
      step();
      chk8("bp_hold", 1'b1, 2);
    end
    req8 = 8'h24; rdy8 = 1'b1;
    step();
    chk8("bp_next", 1'b1, 5);

    // Withdraw and empty: ptr is 6, req 0x08 -> grant 3.
    req8 = 8'h08;
    step();
    chk8("wd_load", 1'b1, 3);
    req8 = 8'h00; rdy8 = 1'b0;
    step();
    chk8("wd_hold", 1'b1, 3);
    rdy8 = 1'b1;
    step();
    chk8("wd_empty", 1'b0, 0);
    step();
    chk8("wd_stay", 1'b0, 0);

    // Asynchronous reset while FULL: ptr is 4, all requesting -> grant 4.
    req8 = 8'hFF;
    step();
    chk8("ar_load", 1'b1, 4);
    rdy8 = 1'b0;
    #2 rst = 1'b1;
    #1 chk8("ar_clear", 1'b0, 0);
    #1 rst = 1'b0;
    rdy8 = 1'b1;
    step();
    chk8("ar_restart", 1'b1, 0);

`ifdef GPGPU_RR_ARB_BIN_LOCK_EN
    // ptr is 1; first handshake has req[0]=0 so normal arbitration picks 1.
    req8 = 8'h0A; lock8 = 1'b1;
    step();
    chk8("lk_first", 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk8("lk_hold", 1'b1, 1);
    end
    lock8 = 1'b0;
    step();
    chk8("lk_release", 1'b1, 3);
`endif

    // Non-power-of-two wrap: grant 3 moves ptr to 4, then 4,0,4,0.
    req8 = 8'h00; rdy8 = 1'b0;
    req5 = 5'b01000; rdy5 = 1'b1;
    step();
    chk5("n5_pre", 3);
    req5 = 5'b10001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk5("n5_wrap", (k % 2 == 0) ? 4 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
